// File: rtl/apuracao_paramet.sv
// apuracao_paramet: parametrised election tally with a sequential ranking scan.
//
// The block collects ballots and judge tie-break votes for N_CAND candidates.
// On close it visits one candidate per cycle and keeps the best and the
// second-best key, where key = {ballots, judge votes}. It then reports the
// winner and the runner-up.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   vote_valid/vote_cand          one ballot per cycle
//   judge_valid/judge_id/_cand    one judge vote per cycle, one vote per judge
//   close                         end collection and start the ranking scan
//   clear                         drop the result / counters, restart collection
//   rd_idx -> rd_count            combinational read of one ballot counter
//   candidato1/2, votos1/2        winner / runner-up index and ballot count
//   empate                        winner and runner-up have equal ballot counts
//   done                          result valid (level)
//   rejected                      one-cycle pulse: a vote was dropped
//   saturated                     sticky: a ballot hit a full counter
module apuracao_paramet #(
    parameter int N_CAND = 4,
    parameter int VOTE_W = 6,
    parameter int N_JUIZ = 4,
    localparam int CW  = $clog2(N_CAND),
    localparam int JIW = (N_JUIZ > 1) ? $clog2(N_JUIZ) : 1,
    localparam int JVW = $clog2(N_JUIZ + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vote_valid,
    input  logic [CW-1:0]     vote_cand,
    input  logic              judge_valid,
    input  logic [JIW-1:0]    judge_id,
    input  logic [CW-1:0]     judge_cand,
    input  logic              close,
    input  logic              clear,
    input  logic [CW-1:0]     rd_idx,
    output logic [VOTE_W-1:0] rd_count,
    output logic [CW-1:0]     candidato1,
    output logic [CW-1:0]     candidato2,
    output logic [VOTE_W-1:0] votos1,
    output logic [VOTE_W-1:0] votos2,
    output logic              empate,
    output logic              done,
    output logic              rejected,
    output logic              saturated
);

    typedef enum logic [1:0] {S_COLLECT = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

    localparam int KW = VOTE_W + JVW;
    localparam logic [CW:0]       NC_L     = (CW + 1)'(N_CAND);
    localparam logic [JIW:0]      NJ_L     = (JIW + 1)'(N_JUIZ);
    localparam logic [CW-1:0]     LAST_L   = CW'(N_CAND - 1);
    localparam logic [VOTE_W-1:0] CNT_MAX  = '1;

    state_t                   state_q, state_d;
    logic [CW-1:0]            idx_q, idx_d, best_q, best_d, second_q, second_d;
    logic                     secv_q, secv_d;
    logic [VOTE_W-1:0]        cnt_q  [N_CAND];
    logic [VOTE_W-1:0]        cnt_d  [N_CAND];
    logic [JVW-1:0]           jcnt_q [N_CAND];
    logic [JVW-1:0]           jcnt_d [N_CAND];
    logic [N_JUIZ-1:0]        used_q, used_d;
    logic [CW-1:0]            cand1_q, cand1_d, cand2_q, cand2_d;
    logic [VOTE_W-1:0]        votos1_q, votos1_d, votos2_q, votos2_d;
    logic                     empate_q, empate_d, done_q, done_d;
    logic                     rejected_q, rejected_d, saturated_q, saturated_d;

    logic                     collect_s, vote_ok_s, judge_ok_s, used_hit_s, drop_s;
    logic [N_JUIZ-1:0]        judge_bit_s;
    logic [KW-1:0]            key_cur_s, key_best_s, key_sec_s;

    // Range and duplicate checks on the incoming votes.
    assign collect_s   = (state_q == S_COLLECT);
    assign judge_bit_s = N_JUIZ'(1'b1) << judge_id;
    assign used_hit_s  = |(used_q & judge_bit_s);
    assign vote_ok_s   = ({1'b0, vote_cand} < NC_L);
    assign judge_ok_s  = ({1'b0, judge_id} < NJ_L) && ({1'b0, judge_cand} < NC_L) && !used_hit_s;
    // Anything presented outside COLLECT, or failing the checks, is dropped.
    assign drop_s      = (vote_valid  && !(collect_s && vote_ok_s)) ||
                         (judge_valid && !(collect_s && judge_ok_s));

    // Keys under comparison; ballots dominate, judge votes break ties.
    assign key_cur_s   = {cnt_q[idx_q],    jcnt_q[idx_q]};
    assign key_best_s  = {cnt_q[best_q],   jcnt_q[best_q]};
    assign key_sec_s   = {cnt_q[second_q], jcnt_q[second_q]};

    assign rd_count    = ({1'b0, rd_idx} < NC_L) ? cnt_q[rd_idx] : '0;
    assign candidato1  = cand1_q;
    assign candidato2  = cand2_q;
    assign votos1      = votos1_q;
    assign votos2      = votos2_q;
    assign empate      = empate_q;
    assign done        = done_q;
    assign rejected    = rejected_q;
    assign saturated   = saturated_q;

    // Next-state logic: collection, ranking scan and result hold.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        best_d      = best_q;
        second_d    = second_q;
        secv_d      = secv_q;
        cnt_d       = cnt_q;
        jcnt_d      = jcnt_q;
        used_d      = used_q;
        cand1_d     = cand1_q;
        cand2_d     = cand2_q;
        votos1_d    = votos1_q;
        votos2_d    = votos2_q;
        empate_d    = empate_q;
        done_d      = done_q;
        rejected_d  = drop_s;
        saturated_d = saturated_q;

        case (state_q)
            S_COLLECT: begin
                if (vote_valid && vote_ok_s) begin
                    if (cnt_q[vote_cand] == CNT_MAX) begin
                        saturated_d = 1'b1;
                    end else begin
                        cnt_d[vote_cand] = cnt_q[vote_cand] + VOTE_W'(1'b1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                if (judge_valid && judge_ok_s) begin
                    jcnt_d[judge_cand] = jcnt_q[judge_cand] + JVW'(1'b1);
                    used_d             = used_q | judge_bit_s;
                end else begin
                    used_d = used_q;
                end
                if (close) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_SCAN: begin
                if (idx_q == '0) begin
                    best_d = '0;
                    secv_d = 1'b0;
                end else if (key_cur_s > key_best_s) begin
                    second_d = best_q;
                    secv_d   = 1'b1;
                    best_d   = idx_q;
                end else if (!secv_q || (key_cur_s > key_sec_s)) begin
                    second_d = idx_q;
                    secv_d   = 1'b1;
                end else begin
                    best_d = best_q;
                end
                if (idx_q == LAST_L) begin
                    cand1_d  = best_d;
                    cand2_d  = second_d;
                    votos1_d = cnt_q[best_d];
                    votos2_d = cnt_q[second_d];
                    empate_d = (cnt_q[best_d] == cnt_q[second_d]);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + CW'(1'b1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase

        // clear in COLLECT or DONE wipes the election; it is ignored mid-scan.
        if (clear && (state_q != S_SCAN)) begin
            for (int i = 0; i < N_CAND; i++) begin
                cnt_d[i]  = '0;
                jcnt_d[i] = '0;
            end
            used_d      = '0;
            cand1_d     = '0;
            cand2_d     = '0;
            votos1_d    = '0;
            votos2_d    = '0;
            empate_d    = 1'b0;
            done_d      = 1'b0;
            saturated_d = 1'b0;
            state_d     = S_COLLECT;
        end else begin
            done_d = done_d;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            idx_q       <= '0;
            best_q      <= '0;
            second_q    <= '0;
            secv_q      <= 1'b0;
            for (int i = 0; i < N_CAND; i++) begin
                cnt_q[i]  <= '0;
                jcnt_q[i] <= '0;
            end
            used_q      <= '0;
            cand1_q     <= '0;
            cand2_q     <= '0;
            votos1_q    <= '0;
            votos2_q    <= '0;
            empate_q    <= 1'b0;
            done_q      <= 1'b0;
            rejected_q  <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            second_q    <= second_d;
            secv_q      <= secv_d;
            cnt_q       <= cnt_d;
            jcnt_q      <= jcnt_d;
            used_q      <= used_d;
            cand1_q     <= cand1_d;
            cand2_q     <= cand2_d;
            votos1_q    <= votos1_d;
            votos2_q    <= votos2_d;
            empate_q    <= empate_d;
            done_q      <= done_d;
            rejected_q  <= rejected_d;
            saturated_q <= saturated_d;
        end
    end

endmodule
